// File: rtl/flash_read_arbiter_if.sv
// Avalon-MM read-only bus between the arbiter (master) and the flash controller (slave).
// The slave accepts a read on a clock edge where flash_mem_read=1 and flash_mem_waitrequest=0; the word
// returns later as a one-cycle flash_mem_readdatavalid beat with flash_mem_readdata.
interface flash_read_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_byteenable,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM flash read port between two word-read requesters,
// with a watchdog that answers 32'hDEAD_BEEF when the flash never returns data.
module flash_read_arbiter #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              owner,
  output logic              timeout_err,
  output logic [1:0]        dbg_state,
  flash_read_arbiter_if.master flash
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [DATA_W-1:0] DEAD_WORD = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t            state, state_n;
  logic              read_q, read_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              rv0_n, rv1_n;
  logic [DATA_W-1:0] rd0_n, rd1_n;
  logic              owner_n, last_owner, last_n;
  logic              terr_n;
  logic [WD_W-1:0]   wdog, wdog_n;
  logic              gnt;

  assign flash.flash_mem_read       = read_q;
  assign flash.flash_mem_address    = addr_q;
  assign flash.flash_mem_byteenable = 4'b1111;
  assign dbg_state                  = state;

  always_comb begin
    state_n = state;
    read_n  = read_q;
    addr_n  = addr_q;
    rv0_n   = 1'b0;
    rv1_n   = 1'b0;
    rd0_n   = r0_rdata;
    rd1_n   = r1_rdata;
    owner_n = owner;
    last_n  = last_owner;
    terr_n  = timeout_err;
    wdog_n  = wdog;
    gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie the port that did not own the previous transaction wins.
          gnt     = (r0_req && r1_req) ? ~last_owner : r1_req;
          owner_n = gnt;
          last_n  = gnt;
          read_n  = 1'b1;
          addr_n  = gnt ? r1_addr : r0_addr;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!flash.flash_mem_waitrequest) begin
          read_n  = 1'b0;
          wdog_n  = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (flash.flash_mem_readdatavalid) begin
          if (owner) begin
            rd1_n = flash.flash_mem_readdata;
            rv1_n = 1'b1;
          end else begin
            rd0_n = flash.flash_mem_readdata;
            rv0_n = 1'b1;
          end
          state_n = RESP;
        end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          terr_n = 1'b1;
          if (owner) begin
            rd1_n = DEAD_WORD;
            rv1_n = 1'b1;
          end else begin
            rd0_n = DEAD_WORD;
            rv0_n = 1'b1;
          end
          state_n = RESP;
        end else begin
          wdog_n = wdog + WD_W'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      read_q      <= 1'b0;
      addr_q      <= '0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      timeout_err <= 1'b0;
      wdog        <= '0;
    end else begin
      state       <= state_n;
      read_q      <= read_n;
      addr_q      <= addr_n;
      r0_rvalid   <= rv0_n;
      r1_rvalid   <= rv1_n;
      r0_rdata    <= rd0_n;
      r1_rdata    <= rd1_n;
      owner       <= owner_n;
      last_owner  <= last_n;
      timeout_err <= terr_n;
      wdog        <= wdog_n;
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: cycle-stepped requesters and flash responder, checked every cycle
// against a transaction-level model of arbitration, watchdog and returned data.
module tb_flash_read_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam logic [DW-1:0] DEAD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r1_req;
  logic [AW-1:0] r0_addr, r1_addr;
  logic          r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          owner, timeout_err;
  logic [1:0]    dbg_state;

  flash_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) flash_bus ();

  flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .owner(owner), .timeout_err(timeout_err), .dbg_state(dbg_state),
    .flash(flash_bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 request on the bus, 2 awaiting data, 3 response cycle.
  int            ph;
  logic          m_port, m_last, m_owner, m_terr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata [2];
  int            wcnt, wait_left, lat;
  int            left [2];

  bit            rand_mode, resp_en, stray_en;
  int            cfg_wait, cfg_lat;
  logic [DW-1:0] cfg_data;

  logic [AW-1:0] acc_q[$];
  logic          grant_q[$];
  logic [DW-1:0] exp_q[$];

  logic [1:0]    p_req;
  logic [AW-1:0] p_addr0, p_addr1;
  logic          p_wait, p_rdv;
  logic [DW-1:0] p_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_last = 1'b1; m_owner = 1'b0; m_terr = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    exp_q.delete();
    left[0] = 0; left[1] = 0;
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  task automatic request(input int port, input logic [AW-1:0] addr, input int count);
    left[port] = count;
    if (port == 0) begin r0_req = 1'b1; r0_addr = addr; end
    else begin r1_req = 1'b1; r1_addr = addr; end
  endtask

  task automatic tick();
    p_req   = {r1_req, r0_req};
    p_addr0 = r0_addr;
    p_addr1 = r1_addr;
    p_wait  = flash_bus.flash_mem_waitrequest;
    p_rdv   = flash_bus.flash_mem_readdatavalid;
    p_data  = flash_bus.flash_mem_readdata;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
      flash_bus.flash_mem_readdatavalid = 1'($urandom_range(0, 1));
      return;
    end
    case (ph)
      0: if (p_req != 2'b00) begin
        m_port  = (p_req == 2'b11) ? ~m_last : p_req[1];
        m_last  = m_port;
        m_owner = m_port;
        m_addr  = m_port ? p_addr1 : p_addr0;
        grant_q.push_back(m_port);
        wait_left = rand_mode ? int'($urandom_range(0, 3)) : cfg_wait;
        ph = 1;
      end
      1: if (!p_wait) begin
        acc_q.push_back(m_addr);
        lat  = rand_mode ? int'($urandom_range(1, 4)) : cfg_lat;
        wcnt = 0;
        ph   = 2;
      end
      2: if (p_rdv) begin
        m_rdata[m_port] = p_data;
        exp_q.push_back(p_data);
        ph = 3;
      end else begin
        wcnt++;
        if (wcnt == T) begin
          m_rdata[m_port] = DEAD;
          m_terr = 1'b1;
          exp_q.push_back(DEAD);
          ph = 3;
        end
      end
      default: ph = 0;
    endcase

    check("flash_read", flash_bus.flash_mem_read, ph == 1);
    if (ph == 1) check("flash_addr", flash_bus.flash_mem_address, m_addr);
    check("byteenable", flash_bus.flash_mem_byteenable, 4'b1111);
    check("owner", owner, m_owner);
    check("r0_rvalid", r0_rvalid, (ph == 3) && !m_port);
    check("r1_rvalid", r1_rvalid, (ph == 3) && m_port);
    check("r0_rdata", r0_rdata, m_rdata[0]);
    check("r1_rdata", r1_rdata, m_rdata[1]);
    check("timeout_err", timeout_err, m_terr);
    if (ph == 3) check("sb_rdata", m_port ? r1_rdata : r0_rdata, exp_q.pop_front());

    // Requesters: one served word per rvalid; keep req high while more words are wanted.
    if (ph == 3) begin
      left[m_port]--;
      if (left[m_port] <= 0) begin
        if (m_port) r1_req = 1'b0; else r0_req = 1'b0;
      end else if (rand_mode) begin
        if (m_port) r1_addr = AW'($urandom); else r0_addr = AW'($urandom);
      end
    end

    if (ph == 1) begin
      if (wait_left > 0) begin flash_bus.flash_mem_waitrequest = 1'b1; wait_left--; end
      else flash_bus.flash_mem_waitrequest = 1'b0;
    end else begin
      flash_bus.flash_mem_waitrequest = 1'($urandom_range(0, 1));
    end

    if (ph == 2) begin
      flash_bus.flash_mem_readdatavalid = resp_en && (wcnt == lat - 1);
      flash_bus.flash_mem_readdata      = rand_mode ? $urandom : cfg_data;
    end else begin
      flash_bus.flash_mem_readdatavalid = stray_en && ($urandom_range(0, 1) == 1);
      flash_bus.flash_mem_readdata      = $urandom;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((left[0] > 0 || left[1] > 0 || ph != 0) && n < max) begin
      tick();
      n++;
    end
    check("drain_budget", n < max, 1'b1);
  endtask

  initial begin
    int base, n0;
    rst_n = 1'b0;
    r0_addr = '0; r1_addr = '0;
    flash_bus.flash_mem_waitrequest   = 1'b0;
    flash_bus.flash_mem_readdatavalid = 1'b0;
    flash_bus.flash_mem_readdata      = '0;
    model_reset();
    rand_mode = 1'b0; resp_en = 1'b1; stray_en = 1'b0;
    cfg_wait = 0; cfg_lat = 2; cfg_data = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_read", flash_bus.flash_mem_read, 1'b0);
    check("rst_addr", flash_bus.flash_mem_address, '0);
    check("rst_r0_rvalid", r0_rvalid, 1'b0);
    check("rst_r1_rvalid", r1_rvalid, 1'b0);
    check("rst_r0_rdata", r0_rdata, '0);
    check("rst_r1_rdata", r1_rdata, '0);
    check("rst_owner", owner, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;

    // Both ports requesting from reset: alternation starting with port 0.
    cfg_data = 32'hA5A5_0001;
    request(0, 23'h000100, 2);
    request(1, 23'h000200, 2);
    drain(200);
    check("alt_g0", grant_q[0], 1'b0);
    check("alt_g1", grant_q[1], 1'b1);
    check("alt_g2", grant_q[2], 1'b0);
    check("alt_g3", grant_q[3], 1'b1);
    check("alt_a0", acc_q[0], 23'h000100);
    check("alt_a1", acc_q[1], 23'h000200);

    // Port 0 alone, two-cycle flash latency.
    cfg_lat = 2; cfg_data = 32'h1234_ABCD;
    request(0, 23'h000010, 1);
    drain(100);
    check("single_addr", acc_q[acc_q.size()-1], 23'h000010);
    check("single_rdata", r0_rdata, 32'h1234_ABCD);

    // Five waitrequest cycles: still exactly one accepted read.
    cfg_wait = 5; cfg_data = 32'h0BAD_F00D;
    n0 = acc_q.size();
    request(1, 23'h000055, 1);
    drain(100);
    check("wait_accepts", acc_q.size(), n0 + 1);

    // Address input changes after grant do not reach the bus.
    cfg_wait = 2; cfg_data = 32'h3003_3003;
    request(1, 23'h000300, 1);
    tick();
    r1_addr = 23'h0003FF;
    drain(100);
    check("addr_latched", acc_q[acc_q.size()-1], 23'h000300);
    cfg_wait = 0;

    // Flash never answers: watchdog returns DEAD_BEEF, then late beats are ignored.
    resp_en = 1'b0;
    request(0, 23'h000444, 1);
    drain(100);
    check("to_rdata", r0_rdata, DEAD);
    check("to_err", timeout_err, 1'b1);
    resp_en = 1'b1; stray_en = 1'b1;
    repeat (10) tick();

    // Randomized traffic with stray beats and random waitrequest outside the bus phase.
    rand_mode = 1'b1;
    request(0, AW'($urandom), 20);
    request(1, AW'($urandom), 20);
    drain(3000);
    rand_mode = 1'b0; stray_en = 1'b0;

    // Reset in the middle of a pending read.
    cfg_lat = 50;
    request(1, 23'h000777, 1);
    for (int i = 0; i < 20 && ph != 2; i++) tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("rstw_read", flash_bus.flash_mem_read, 1'b0);
    check("rstw_r0_rvalid", r0_rvalid, 1'b0);
    check("rstw_r1_rvalid", r1_rvalid, 1'b0);
    check("rstw_timeout_err", timeout_err, 1'b0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    stray_en = 1'b1;
    repeat (4) tick();
    stray_en = 1'b0;
    cfg_lat = 2; cfg_data = 32'h5151_6262;
    base = grant_q.size();
    request(0, 23'h000011, 1);
    request(1, 23'h000022, 1);
    drain(100);
    check("tie_after_reset", grant_q[base], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
